pulse_period_meter: RTL and testbench

- Measurement counterpart to the clock-enable divider. It consumes a periodic strobe, such as a divider `en` output or an external pulse train.
- For each full cycle of the strobe, it reports the period and the high time in clk cycles.
- It sits on the monitor/self-check side of the design and checks generated enables and incoming pulse trains at run time.
- A timeout flags a stalled or stuck input.

---
 rtl/pulse_period_meter.sv | 120 ++++++++++++
 tb/tb_pulse_period_meter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures period and high time (in clk cycles) of a periodic strobe, with a
// stall timeout. Back-to-back periods are reported without a dead cycle.
module pulse_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             armed
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_nx;
  logic             s, s_d, rise;
  logic [CNT_W-1:0] per_cnt, hi_cnt, per_nx, hi_nx;
  logic [CNT_W-1:0] period_nx, high_nx;
  logic             valid_nx, timeout_nx;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = sig;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= sig;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign rise = s & ~s_d;

  // The rise cycle itself starts the next period, so counters restart at 1.
  always_comb begin
    state_nx   = state;
    per_nx     = per_cnt;
    hi_nx      = hi_cnt;
    period_nx  = period;
    high_nx    = high_time;
    valid_nx   = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        per_nx = '0;
        hi_nx  = '0;
        if (en && rise) begin
          state_nx = MEASURE;
          per_nx   = ONE;
          hi_nx    = ONE;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_nx = IDLE;
          per_nx   = '0;
          hi_nx    = '0;
        end else if (rise) begin
          period_nx = per_cnt;
          high_nx   = hi_cnt;
          valid_nx  = 1'b1;
          per_nx    = ONE;
          hi_nx     = ONE;
        end else if (per_cnt == TIMEOUT_C) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
          per_nx     = '0;
          hi_nx      = '0;
        end else begin
          per_nx = per_cnt + ONE;
          hi_nx  = hi_cnt + CNT_W'(s);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      per_cnt   <= per_nx;
      hi_cnt    <= hi_nx;
      period    <= period_nx;
      high_time <= high_nx;
      valid     <= valid_nx;
      timeout   <= timeout_nx;
      armed     <= (state_nx == MEASURE);
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: two instances (unsynchronised and 2-stage
// synchronised, TIMEOUT=10) checked every cycle against a timestamp model.
module tb_pulse_period_meter;

  localparam int CNT_W = 16;
  localparam int TO    = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic sig = 1'b0;

  logic [CNT_W-1:0] period_a, high_a, period_b, high_b;
  logic valid_a, timeout_a, armed_a, valid_b, timeout_b, armed_b;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int tcnt   = 0;

  always #5 clk = ~clk;

  pulse_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sig(sig),
    .period(period_a), .high_time(high_a),
    .valid(valid_a), .timeout(timeout_a), .armed(armed_a)
  );

  pulse_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sig(sig),
    .period(period_b), .high_time(high_b),
    .valid(valid_b), .timeout(timeout_b), .armed(armed_b)
  );

  // Model: remembers the cycle stamp of the last accepted rise and the number
  // of high samples since then; a report is the stamp difference and that sum.
  bit       m_live = 1'b0;
  int       m_cyc  = 0;
  bit [7:0] m_hist [2];
  bit       m_sprev[2];
  bit       m_armed[2];
  int       m_last [2];
  int       m_hisum[2];
  int       m_period[2];
  int       m_high [2];
  bit       m_valid[2];
  bit       m_tmo  [2];

  task automatic model_step(input int i, input int k);
    bit sv;
    bit rise;
    if (rst) begin
      m_hist[i] = '0; m_sprev[i] = 1'b0; m_armed[i] = 1'b0;
      m_period[i] = 0; m_high[i] = 0; m_valid[i] = 1'b0; m_tmo[i] = 1'b0;
      m_hisum[i] = 0; m_last[i] = 0;
    end else begin
      sv = (k == 0) ? sig : m_hist[i][k-1];
      m_hist[i] = {m_hist[i][6:0], sig};
      rise = sv && !m_sprev[i];
      m_sprev[i] = sv;
      m_valid[i] = 1'b0;
      m_tmo[i]   = 1'b0;
      if (!en) begin
        m_armed[i] = 1'b0;
      end else if (rise) begin
        if (m_armed[i]) begin
          m_valid[i]  = 1'b1;
          m_period[i] = m_cyc - m_last[i];
          m_high[i]   = m_hisum[i];
        end
        m_armed[i] = 1'b1;
        m_last[i]  = m_cyc;
        m_hisum[i] = 1;
      end else if (m_armed[i]) begin
        if (m_cyc - m_last[i] == TO) begin
          m_tmo[i]   = 1'b1;
          m_armed[i] = 1'b0;
        end else begin
          m_hisum[i] += int'(sv);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_live = 1'b1;
    model_step(0, 0);
    model_step(1, 2);
    m_cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("a.period",    int'(period_a),  m_period[0]);
      chk("a.high_time", int'(high_a),    m_high[0]);
      chk("a.valid",     int'(valid_a),   int'(m_valid[0]));
      chk("a.timeout",   int'(timeout_a), int'(m_tmo[0]));
      chk("a.armed",     int'(armed_a),   int'(m_armed[0]));
      chk("b.period",    int'(period_b),  m_period[1]);
      chk("b.high_time", int'(high_b),    m_high[1]);
      chk("b.valid",     int'(valid_b),   int'(m_valid[1]));
      chk("b.timeout",   int'(timeout_b), int'(m_tmo[1]));
      chk("b.armed",     int'(armed_b),   int'(m_armed[1]));
    end
  end

  task automatic step(input bit r, input bit e, input bit s_in);
    rst = r;
    en  = e;
    sig = s_in;
    @(posedge clk);
    #1;
    if (valid_a)   vcnt++;
    if (timeout_a) tcnt++;
  endtask

  task automatic pat(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) step(1'b0, 1'b1, 1'b1);
      repeat (lo) step(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("lit.reset_period",  int'(period_a),  0);
    chk("lit.reset_high",    int'(high_a),    0);
    chk("lit.reset_valid",   int'(valid_a),   0);
    chk("lit.reset_timeout", int'(timeout_a), 0);
    chk("lit.reset_armed",   int'(armed_a),   0);

    // Divide-by-4 strobe: six rises give five reports.
    vcnt = 0; tcnt = 0;
    pat(2, 2, 6);
    chk("lit.div4_valids",   vcnt, 5);
    chk("lit.div4_timeouts", tcnt, 0);
    chk("lit.div4_period",   int'(period_a), 4);
    chk("lit.div4_high",     int'(high_a),   2);

    pat(2, 3, 5);
    chk("lit.div5_period", int'(period_a), 5);
    chk("lit.div5_high",   int'(high_a),   2);
    pat(3, 4, 4);
    chk("lit.div7_period", int'(period_a), 7);
    chk("lit.div7_high",   int'(high_a),   3);

    // Stall low: exactly one timeout, last report held.
    vcnt = 0; tcnt = 0;
    repeat (12) step(1'b0, 1'b1, 1'b0);
    chk("lit.tmo_count",  tcnt, 1);
    chk("lit.tmo_valids", vcnt, 0);
    chk("lit.tmo_armed",  int'(armed_a),  0);
    chk("lit.tmo_period", int'(period_a), 7);
    chk("lit.tmo_high",   int'(high_a),   3);

    vcnt = 0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("lit.rearm_valids", vcnt, 0);
    chk("lit.rearm_armed",  int'(armed_a), 1);
    pat(2, 2, 3);

    // Reset in the middle of a period.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("lit.midrst_period", int'(period_a), 0);
    chk("lit.midrst_high",   int'(high_a),   0);
    chk("lit.midrst_valid",  int'(valid_a),  0);
    chk("lit.midrst_armed",  int'(armed_a),  0);
    pat(2, 2, 3);
    chk("lit.postrst_period", int'(period_a), 4);

    // Enable dropped for three cycles mid-period.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    vcnt = 0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("lit.endrop_valids", vcnt, 0);
    chk("lit.endrop_armed",  int'(armed_a), 0);
    pat(2, 2, 3);
    chk("lit.reen_period", int'(period_a), 4);
    chk("lit.reen_high",   int'(high_a),   2);

    // Minimum period.
    pat(1, 1, 8);
    chk("lit.alt_a_period", int'(period_a), 2);
    chk("lit.alt_a_high",   int'(high_a),   1);
    pat(1, 1, 2);
    chk("lit.alt_b_period", int'(period_b), 2);
    chk("lit.alt_b_high",   int'(high_b),   1);

    repeat (4) step(1'b0, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
